// File: rtl/pixel_shadow_buffer_pkg.sv
// ============================================================================
// Module   : pixel_shadow_buffer_pkg
// Brief    : Shared screen geometry, colour constants and xy-to-address map.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pixel_shadow_buffer_pkg;

    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;
    localparam int PIXELS = WIDTH * HEIGHT;
    localparam int ADDR_W = 15;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WALL  = 3'b111;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // y*160 + x built from shifts so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x, input logic [6:0] y);
        return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_shadow_buffer_ram.sv
// ============================================================================
// Module   : pixel_ram
// Brief    : Single-port synchronous RAM, write has priority, 1-cycle read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_ram
    import pixel_shadow_buffer_pkg::*;
#(
    parameter int DEPTH  = PIXELS,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/pixel_shadow_buffer.sv
// ============================================================================
// Module   : pixel_shadow_buffer
// Brief    : Shadow framebuffer with clear sweep, plot writes and read lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_shadow_buffer
    import pixel_shadow_buffer_pkg::*;
#(
    parameter logic [2:0] CLEAR_COLOUR = COL_BLACK,
    parameter logic [2:0] WALL_COLOUR  = COL_WALL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    input  logic       plot,
    input  logic       rd_req,
    input  logic [7:0] rd_x,
    input  logic [6:0] rd_y,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic [2:0] rd_colour,
    input  logic       clear_req,
    output logic       busy,
    output logic       oob_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              oob_q, oob_d;
    logic              pend_q, pend_d;
    logic [7:0]        pend_x_q, pend_x_d;
    logic [6:0]        pend_y_q, pend_y_d;
    logic              svc_q, svc_d;
    logic              wall_q, wall_d;
    logic [2:0]        colour_q, colour_d;

    logic              w_accept, w_have, w_service, w_rd_on, w_wr_on;
    logic [7:0]        w_rd_x;
    logic [6:0]        w_rd_y;
    logic              ram_we, ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [2:0]        ram_wdata, ram_rdata;

    assign rd_ready = (state_q == ST_IDLE) && !pend_q;
    assign busy     = (state_q == ST_CLEAR);
    assign oob_err  = oob_q;
    assign rd_valid = svc_q;
    // The RAM output register is the first-cycle result; colour_q keeps it afterwards.
    assign rd_colour = svc_q ? (wall_q ? WALL_COLOUR : ram_rdata) : colour_q;

    assign w_accept = rd_req && rd_ready;
    assign w_have   = pend_q || w_accept;
    assign w_rd_x   = pend_q ? pend_x_q : rd_x;
    assign w_rd_y   = pend_q ? pend_y_q : rd_y;
    assign w_rd_on  = (w_rd_x < 8'(WIDTH)) && (w_rd_y < 7'(HEIGHT));
    assign w_wr_on  = (x_in < 8'(WIDTH)) && (y_in < 7'(HEIGHT));

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        oob_d     = oob_q;
        pend_d    = pend_q;
        pend_x_d  = pend_x_q;
        pend_y_d  = pend_y_q;
        colour_d  = svc_q ? rd_colour : colour_q;
        w_service = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = xy_to_addr(w_rd_x, w_rd_y);
        ram_wdata = colour_in;

        if (w_accept) begin
            pend_x_d = rd_x;
            pend_y_d = rd_y;
        end

        case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = sweep_q;
                ram_wdata = CLEAR_COLOUR;
                sweep_d   = sweep_q + 1'b1;
                if (sweep_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                    oob_d   = 1'b0;
                end else if (plot) begin
                    if (w_wr_on) begin
                        ram_we   = 1'b1;
                        ram_addr = xy_to_addr(x_in, y_in);
                    end else begin
                        oob_d = 1'b1;
                    end
                end
                // The read port is free whenever plot is low.
                w_service = w_have && !plot;
            end
            default: state_d = ST_CLEAR;
        endcase

        pend_d = w_have && !w_service;
        svc_d  = w_service;
        wall_d = w_service && !w_rd_on;
        ram_en = w_service && w_rd_on;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_CLEAR;
            sweep_q  <= '0;
            oob_q    <= 1'b0;
            pend_q   <= 1'b0;
            pend_x_q <= '0;
            pend_y_q <= '0;
            svc_q    <= 1'b0;
            wall_q   <= 1'b0;
            colour_q <= COL_BLACK;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            oob_q    <= oob_d;
            pend_q   <= pend_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
            svc_q    <= svc_d;
            wall_q   <= wall_d;
            colour_q <= colour_d;
        end
    end

    pixel_ram #(
        .DEPTH  (PIXELS),
        .DATA_W (3)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .en_i    (ram_en),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_pixel_shadow_buffer.sv
// ============================================================================
// Module   : tb_pixel_shadow_buffer
// Brief    : Directed bench with a read scoreboard for pixel_shadow_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_shadow_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic       plot;
    logic       rd_req;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic       rd_ready;
    logic       rd_valid;
    logic [2:0] rd_colour;
    logic       clear_req;
    logic       busy;
    logic       oob_err;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q [$];

    always #5 clk = ~clk;

    pixel_shadow_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .y_in      (y_in),
        .colour_in (colour_in),
        .plot      (plot),
        .rd_req    (rd_req),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_colour (rd_colour),
        .clear_req (clear_req),
        .busy      (busy),
        .oob_err   (oob_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rd_valid must match the oldest expected colour.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_rd_valid: observed rd_valid 1 expected 0");
            end
            if (exp_q.size() > 0) begin
                logic [2:0] e;
                e = exp_q.pop_front();
                checks++;
                assert (rd_colour === e) else begin
                    errors++;
                    $error("FAIL rd_colour: observed %0h expected %0h", rd_colour, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 20000) begin
            n++;
            step();
        end
        check(tag, n, 19200);
    endtask

    task automatic do_read(input string tag, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] exp, input int exp_lat);
        int lat;
        check({tag, "_ready"}, rd_ready, 1);
        rd_req = 1'b1;
        rd_x   = x;
        rd_y   = y;
        exp_q.push_back(exp);
        step();
        rd_req = 1'b0;
        lat = 1;
        while (rd_valid !== 1'b1 && lat < 64) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic plot_px(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        plot      = 1'b1;
        x_in      = x;
        y_in      = y;
        colour_in = c;
        step();
        plot = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b0; x_in = '0; y_in = '0; colour_in = '0; plot = 1'b0;
        rd_req = 1'b0; rd_x = '0; rd_y = '0; clear_req = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_busy", busy, 1);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_colour", rd_colour, 0);
        check("rst_oob", oob_err, 0);
        rst = 1'b1;
        count_busy("clear_len");
        check("post_clear_ready", rd_ready, 1);

        do_read("rd_0_0", 8'd0, 7'd0, 3'b000, 1);
        do_read("rd_159_119", 8'd159, 7'd119, 3'b000, 1);
        do_read("rd_80_60", 8'd80, 7'd60, 3'b000, 1);

        // Write then read, plus hold of rd_colour
        plot_px(8'd10, 7'd20, 3'b010);
        do_read("wr_rd", 8'd10, 7'd20, 3'b010, 1);
        step();
        check("hold_valid", rd_valid, 0);
        check("hold_colour", rd_colour, 3'b010);

        // Collision: plot held for three cycles alongside the read
        plot = 1'b1; x_in = 8'd10; y_in = 7'd20; colour_in = 3'b100;
        rd_req = 1'b1; rd_x = 8'd10; rd_y = 7'd20;
        exp_q.push_back(3'b100);
        step();
        rd_req = 1'b0;
        check("coll_ready_low", rd_ready, 0);
        n = 1;
        while (rd_valid !== 1'b1 && n < 64) begin
            if (n == 3) plot = 1'b0;
            step();
            n++;
        end
        plot = 1'b0;
        check("coll_lat", n, 4);
        check("coll_ready_back", rd_ready, 1);

        // Off-screen write and read
        plot_px(8'd160, 7'd5, 3'b001);
        check("oob_set", oob_err, 1);
        do_read("oob_neighbour", 8'd0, 7'd6, 3'b000, 1);
        do_read("wall_read", 8'd200, 7'd130, 3'b111, 1);

        // Clear mid-game
        plot_px(8'd5, 7'd5, 3'b110);
        do_read("pre_clear", 8'd5, 7'd5, 3'b110, 1);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("clear_busy", busy, 1);
        check("clear_oob", oob_err, 0);
        n = 0;
        while (busy === 1'b1 && n < 20000) begin
            if (n == 0) begin
                check("busy_ready_low", rd_ready, 0);
                plot = 1'b1; x_in = 8'd6; y_in = 7'd6; colour_in = 3'b011;
                rd_req = 1'b1; rd_x = 8'd6; rd_y = 7'd6;
            end else begin
                plot = 1'b0; rd_req = 1'b0;
            end
            n++;
            step();
        end
        plot = 1'b0; rd_req = 1'b0;
        check("clear2_len", n, 19200);
        do_read("clr_5_5", 8'd5, 7'd5, 3'b000, 1);
        do_read("clr_6_6", 8'd6, 7'd6, 3'b000, 1);

        // Reset with a read starved by plot
        plot = 1'b1; x_in = 8'd1; y_in = 7'd1; colour_in = 3'b101;
        rd_req = 1'b1; rd_x = 8'd1; rd_y = 7'd1;
        step();
        rd_req = 1'b0;
        check("mid_pending", rd_ready, 0);
        rst = 1'b0;
        plot = 1'b0;
        #1;
        check("mid_busy_now", busy, 1);
        check("mid_valid_low", rd_valid, 0);
        repeat (3) step();
        rst = 1'b1;
        count_busy("restart_len");
        do_read("restart_1_1", 8'd1, 7'd1, 3'b000, 1);

        step();
        check("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
